// File: rtl/vga_ball_ctrl_if.sv
// vga_ball_ctrl_if: Avalon-MM slave bus (chipselect, write, read, address[2:0], writedata[15:0], readdata[15:0])
interface vga_ball_ctrl_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;
    modport master (output chipselect, write, read, address, writedata, input readdata);
    modport slave (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/vga_ball_ctrl.sv
// vga_ball_ctrl: frame-synchronous ball registers; ports clk50, reset, bus (Avalon slave), vga_vs_n, hpos, vpos, radius, irq
module vga_ball_ctrl #(
    parameter int HMAX    = 639,
    parameter int VMAX    = 479,
    parameter int RMAX    = 239,
    parameter int RESET_R = 16
) (
    input  logic              clk50,
    input  logic              reset,
    vga_ball_ctrl_if.slave    bus,
    input  logic              vga_vs_n,
    output logic [9:0]        hpos,
    output logic [8:0]        vpos,
    output logic [9:0]        radius,
    output logic              irq
);
    typedef enum logic [1:0] {IDLE, COMMIT, MOVE, DONE} state_t;
    localparam logic [11:0] HM = 12'(HMAX);
    localparam logic [11:0] VM = 12'(VMAX);
    localparam logic [9:0]  RM = 10'(RMAX);
    localparam logic [9:0]  RR = 10'(RESET_R);
    state_t      state, nxt;
    logic [9:0]  sh_h, sh_r;
    logic [8:0]  sh_v;
    logic [7:0]  dx, dy, dx_n, dy_n;
    logic        auto_en, ie, pending, irq_flag, vs_q, tick, wr, rd, sh_wr;
    logic [15:0] frames, rd_val;
    logic [11:0] cr, ch, cv, ch_hi, cv_hi, c_h, c_v;
    logic [11:0] rr, mh_hi, mv_hi, nh, nv, m_h, m_v;
    logic        h_hi, h_lo, v_hi, v_lo;
    function automatic logic [7:0] neg(input logic [7:0] v);
        return v == 8'h80 ? 8'h7f : ~v + 8'd1;
    endfunction
    assign tick  = vs_q & ~vga_vs_n;
    assign wr    = bus.chipselect & bus.write;
    assign rd    = bus.chipselect & bus.read;
    assign sh_wr = wr && bus.address <= 3'd2;
    assign irq   = irq_flag & ie;
    always_comb begin
        nxt = state == IDLE ? (tick ? COMMIT : IDLE) : state == COMMIT ? MOVE : state == MOVE ? DONE : IDLE;
    end
    always_ff @(posedge clk50) state <= reset ? IDLE : nxt;
    // commit clamp keeps the whole ball on screen using the incoming radius
    always_comb begin
        cr    = {2'b0, sh_r};
        ch    = {2'b0, sh_h};
        cv    = {3'b0, sh_v};
        ch_hi = HM - cr;
        cv_hi = VM - cr;
        c_h   = ch < cr ? cr : ch > ch_hi ? ch_hi : ch;
        c_v   = cv < cr ? cr : cv > cv_hi ? cv_hi : cv;
    end
    // motion step in 12-bit signed so a negative step below column 0 compares correctly
    always_comb begin
        rr    = {2'b0, radius};
        mh_hi = HM - rr;
        mv_hi = VM - rr;
        nh    = {2'b0, hpos} + {{4{dx[7]}}, dx};
        nv    = {3'b0, vpos} + {{4{dy[7]}}, dy};
        h_hi  = $signed(nh) > $signed(mh_hi);
        h_lo  = $signed(nh) < $signed(rr);
        v_hi  = $signed(nv) > $signed(mv_hi);
        v_lo  = $signed(nv) < $signed(rr);
        m_h   = h_hi ? mh_hi : h_lo ? rr : nh;
        m_v   = v_hi ? mv_hi : v_lo ? rr : nv;
        dx_n  = h_hi | h_lo ? neg(dx) : dx;
        dy_n  = v_hi | v_lo ? neg(dy) : dy;
    end
    always_comb begin
        rd_val = bus.address == 3'd0 ? {6'b0, sh_h} :
                 bus.address == 3'd1 ? {7'b0, sh_v} :
                 bus.address == 3'd2 ? {6'b0, sh_r} :
                 bus.address == 3'd3 ? {14'b0, ie, auto_en} :
                 bus.address == 3'd4 ? {dy, dx} :
                 bus.address == 3'd5 ? {14'b0, irq_flag, pending} :
                 bus.address == 3'd6 ? frames : 16'h0;
    end
    always_ff @(posedge clk50) begin
        if (reset) begin
            hpos <= 10'd320;
            vpos <= 9'd240;
            radius <= RR;
            sh_h <= 10'd320;
            sh_v <= 9'd240;
            sh_r <= RR;
            dx <= '0;
            dy <= '0;
            auto_en <= 1'b0;
            ie <= 1'b0;
            pending <= 1'b0;
            irq_flag <= 1'b0;
            frames <= '0;
            bus.readdata <= '0;
            vs_q <= 1'b1;
        end else begin
            vs_q <= vga_vs_n;
            if (state == COMMIT && pending) begin
                radius <= sh_r;
                hpos <= c_h[9:0];
                vpos <= c_v[8:0];
            end
            if (state == MOVE && auto_en) begin
                hpos <= m_h[9:0];
                vpos <= m_v[8:0];
                dx <= dx_n;
                dy <= dy_n;
            end
            if (state == DONE) frames <= frames + 16'd1;
            // a shadow write in the COMMIT cycle re-arms pending for the next frame
            pending <= sh_wr | (pending & state != COMMIT);
            // DONE sets the flag after the clear so a same-cycle clear loses
            irq_flag <= state == DONE | (irq_flag & ~(wr && bus.address == 3'd5 && bus.writedata[1]));
            if (wr && bus.address == 3'd0) sh_h <= bus.writedata[9:0];
            if (wr && bus.address == 3'd1) sh_v <= bus.writedata[8:0];
            if (wr && bus.address == 3'd2) sh_r <= bus.writedata[9:0] > RM ? RM : bus.writedata[9:0];
            if (wr && bus.address == 3'd3) {ie, auto_en} <= bus.writedata[1:0];
            // placed after the motion update so a software velocity write wins
            if (wr && bus.address == 3'd4) {dy, dx} <= bus.writedata;
            if (rd) bus.readdata <= rd_val;
        end
    end
endmodule

// File: tb/tb_vga_ball_ctrl.sv
// tb_vga_ball_ctrl: directed self-checking bench for vga_ball_ctrl
module tb_vga_ball_ctrl;
    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic       vga_vs_n = 1'b1;
    logic [9:0] hpos, radius;
    logic [8:0] vpos;
    logic       irq;
    logic [15:0] d;
    int n_cmp = 0, n_bad = 0;
    vga_ball_ctrl_if bus ();
    vga_ball_ctrl dut (.clk50(clk50), .reset(reset), .bus(bus), .vga_vs_n(vga_vs_n),
                       .hpos(hpos), .vpos(vpos), .radius(radius), .irq(irq));
    always #5 clk50 = ~clk50;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic bus_wr(input logic [2:0] a, input logic [15:0] v);
        @(negedge clk50);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = v;
        @(negedge clk50);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask
    task automatic bus_rd(input logic [2:0] a, output logic [15:0] v);
        @(negedge clk50);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(negedge clk50);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        v = bus.readdata;
    endtask
    // kind 0: bus write presented 'at' cycles after vsync falls; kind 1: reset pulse there
    task automatic frame_ev(input int at, input int kind, input logic [2:0] a, input logic [15:0] v);
        @(negedge clk50);
        vga_vs_n = 1'b0;
        repeat (at) @(negedge clk50);
        if (kind == 0) begin
            bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = v;
        end else begin
            reset = 1'b1; vga_vs_n = 1'b1;
        end
        @(negedge clk50);
        bus.chipselect = 1'b0; bus.write = 1'b0; reset = 1'b0;
        repeat (5) @(negedge clk50);
        vga_vs_n = 1'b1;
        @(negedge clk50);
    endtask
    task automatic frame();
        @(negedge clk50);
        vga_vs_n = 1'b0;
        repeat (6) @(negedge clk50);
        vga_vs_n = 1'b1;
        @(negedge clk50);
    endtask
    initial begin
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writedata = '0;
        repeat (3) @(negedge clk50);
        reset = 1'b0;
        @(negedge clk50);
        check("rst_hpos", hpos, 320);
        check("rst_vpos", vpos, 240);
        check("rst_radius", radius, 16);
        check("rst_irq", irq, 0);
        check("rst_readdata", bus.readdata, 0);
        bus_rd(6, d); check("rst_frames", d, 0);
        bus_wr(0, 100); bus_wr(1, 50); bus_wr(2, 20);
        check("pre_tick_hpos", hpos, 320);
        bus_rd(5, d); check("pending_set", d, 1);
        frame();
        check("commit_hpos", hpos, 100);
        check("commit_vpos", vpos, 50);
        check("commit_radius", radius, 20);
        bus_rd(5, d); check("status_after_commit", d, 2);
        check("irq_masked", irq, 0);
        bus_rd(6, d); check("frames_1", d, 1);
        bus_wr(2, 300);
        bus_rd(2, d); check("radius_clamp", d, 239);
        bus_wr(0, 5); bus_wr(2, 30);
        frame();
        check("hpos_clamp_lo", hpos, 30);
        check("radius_30", radius, 30);
        bus_wr(0, 620); bus_wr(2, 10);
        frame();
        check("hpos_620", hpos, 620);
        bus_wr(4, 16'h000F); bus_wr(3, 1);
        frame();
        check("bounce_hpos", hpos, 629);
        bus_rd(4, d); check("bounce_vel", d, 16'h00F1);
        frame();
        check("move_back_hpos", hpos, 614);
        check("move_vpos_still", vpos, 50);
        bus_wr(3, 0);
        bus_wr(5, 2); bus_wr(3, 2);
        check("irq_cleared", irq, 0);
        frame();
        check("irq_set", irq, 1);
        bus_wr(5, 2);
        check("irq_clear_write", irq, 0);
        frame_ev(3, 0, 5, 2);
        check("irq_clear_on_done_loses", irq, 1);
        bus_rd(6, d); check("frames_7", d, 7);
        frame_ev(1, 0, 0, 200);
        check("commit_cycle_write_hpos", hpos, 614);
        bus_rd(5, d); check("commit_cycle_pending", d, 3);
        frame();
        check("next_frame_hpos", hpos, 200);
        bus_wr(0, 300);
        frame_ev(2, 1, 0, 0);
        check("rst_mid_hpos", hpos, 320);
        check("rst_mid_vpos", vpos, 240);
        check("rst_mid_radius", radius, 16);
        bus_rd(5, d); check("rst_mid_status", d, 0);
        bus_rd(6, d); check("rst_mid_frames", d, 0);
        bus_wr(4, 16'h0080); bus_wr(3, 1);
        frame(); frame(); frame();
        check("sat_hpos", hpos, 16);
        bus_rd(4, d); check("sat_vel", d, 16'h007F);
        check("sat_vpos", vpos, 240);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
